// File: rtl/rob_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// rob_commit_ctrl_if
//   Bundles the issue, writeback, operand-query, flush and commit traffic of
//   rob_commit_ctrl. clk, rst and rdy stay plain ports on the block itself.
//
//   master : the pipeline side (issuer, CDB, decoder, register file).
//   slave  : the reorder buffer.
//
//   Issue   : issue, issue_rd           -> issue_rob_pos, full, empty
//   WB/CDB  : wb_valid, wb_rob_pos, wb_val
//   Query   : q_rob_pos1/2              -> q_ready1/2, q_val1/2
//   Flush   : flush
//   Commit  :                           -> commit, commit_rd, commit_val,
//                                          commit_rob_pos
// ---------------------------------------------------------------------------
interface rob_commit_ctrl_if #(
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32,
  parameter int REG_POS_W = 5
);
  // issue / allocation
  logic                 issue;
  logic [REG_POS_W-1:0] issue_rd;
  logic [ROB_POS_W-1:0] issue_rob_pos;
  logic                 full;
  logic                 empty;
  // writeback
  logic                 wb_valid;
  logic [ROB_POS_W-1:0] wb_rob_pos;
  logic [DATA_W-1:0]    wb_val;
  // decoder operand queries
  logic [ROB_POS_W-1:0] q_rob_pos1;
  logic [ROB_POS_W-1:0] q_rob_pos2;
  logic                 q_ready1;
  logic                 q_ready2;
  logic [DATA_W-1:0]    q_val1;
  logic [DATA_W-1:0]    q_val2;
  // pipeline flush
  logic                 flush;
  // register file commit port
  logic                 commit;
  logic [REG_POS_W-1:0] commit_rd;
  logic [DATA_W-1:0]    commit_val;
  logic [ROB_POS_W-1:0] commit_rob_pos;

  modport master (
    output issue, issue_rd, wb_valid, wb_rob_pos, wb_val,
           q_rob_pos1, q_rob_pos2, flush,
    input  issue_rob_pos, full, empty, q_ready1, q_ready2, q_val1, q_val2,
           commit, commit_rd, commit_val, commit_rob_pos
  );

  modport slave (
    input  issue, issue_rd, wb_valid, wb_rob_pos, wb_val,
           q_rob_pos1, q_rob_pos2, flush,
    output issue_rob_pos, full, empty, q_ready1, q_ready2, q_val1, q_val2,
           commit, commit_rd, commit_val, commit_rob_pos
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rob_commit_ctrl
//   In-order reorder-buffer commit controller. Hands out a tag (ROB position)
//   per issued instruction, captures writeback results against that tag,
//   retires entries strictly in program order onto the register file commit
//   port and answers two decoder operand queries. A flush discards everything.
//
//   Ports
//     clk  : clock
//     rst  : synchronous active-high reset (wins over rdy)
//     rdy  : global enable; when low every register holds
//     bus  : rob_commit_ctrl_if.slave (issue / wb / query / flush / commit)
//
//   Optional feature
//     ROB_QUERY_FWD_EN : when defined, a same-cycle writeback to a busy
//                        queried entry is forwarded straight to q_readyN /
//                        q_valN. When undefined, queries see stored state
//                        only and a writeback shows up one cycle later.
// ---------------------------------------------------------------------------

// One ROB slot. Allocation wins over a writeback to the same slot in the
// same cycle (the slot was not busy before the edge, so that writeback is
// stale by definition). Retire and allocate never hit the same slot in one
// cycle: head == tail only when empty (nothing to retire) or full (no
// allocation accepted).
module rob_commit_ctrl_entry #(
  parameter int DATA_W    = 32,
  parameter int REG_POS_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 alloc_i,
  input  logic [REG_POS_W-1:0] alloc_rd_i,
  input  logic                 wb_i,
  input  logic [DATA_W-1:0]    wb_val_i,
  input  logic                 retire_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [REG_POS_W-1:0] rd_o,
  output logic [DATA_W-1:0]    val_o
);
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [REG_POS_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]    val_q, val_d;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    val_d   = val_q;
    if (clr_i) begin
      busy_d  = 1'b0;
      ready_d = 1'b0;
    end else if (alloc_i) begin
      busy_d  = 1'b1;
      ready_d = 1'b0;
      rd_d    = alloc_rd_i;
    end else begin
      if (wb_i && busy_q) begin
        ready_d = 1'b1;
        val_d   = wb_val_i;
      end
      // retire takes the slot out of service; clearing ready as well keeps a
      // freed slot from ever looking done to a query
      if (retire_i) begin
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= '0;
      val_q   <= '0;
    end else if (en_i) begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign rd_o    = rd_q;
  assign val_o   = val_q;
endmodule

module rob_commit_ctrl #(
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32,
  parameter int REG_POS_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  rob_commit_ctrl_if.slave   bus
);
  localparam int DEPTH = 1 << ROB_POS_W;
  localparam int CNT_W = ROB_POS_W + 1;
  localparam int NQ    = 2;

  // ---------------- pointers, count, commit registers ----------------
  logic [ROB_POS_W-1:0] head_q, head_d;
  logic [ROB_POS_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 commit_q, commit_d;
  logic [REG_POS_W-1:0] commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]    commit_val_q, commit_val_d;
  logic [ROB_POS_W-1:0] commit_pos_q, commit_pos_d;

  // ---------------- per-entry state, flattened ----------------
  logic [DEPTH-1:0]                 busy;
  logic [DEPTH-1:0]                 ready;
  logic [DEPTH-1:0][REG_POS_W-1:0]  rd_arr;
  logic [DEPTH-1:0][DATA_W-1:0]     val_arr;

  logic full, empty;
  logic do_issue, do_commit;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // full and the head entry are both judged on pre-edge state, so an issue
  // arriving while full is rejected even if a retire frees a slot this edge
  assign do_issue  = bus.issue && !full && !bus.flush;
  assign do_commit = busy[head_q] && ready[head_q] && !bus.flush;

  // ---------------- entry array ----------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rob_commit_ctrl_entry #(
      .DATA_W    (DATA_W),
      .REG_POS_W (REG_POS_W)
    ) u_ent (
      .clk        (clk),
      .rst        (rst),
      .en_i       (rdy),
      .clr_i      (bus.flush),
      .alloc_i    (do_issue && (tail_q == ROB_POS_W'(g))),
      .alloc_rd_i (bus.issue_rd),
      .wb_i       (bus.wb_valid && (bus.wb_rob_pos == ROB_POS_W'(g))),
      .wb_val_i   (bus.wb_val),
      .retire_i   (do_commit && (head_q == ROB_POS_W'(g))),
      .busy_o     (busy[g]),
      .ready_o    (ready[g]),
      .rd_o       (rd_arr[g]),
      .val_o      (val_arr[g])
    );
  end

  // ---------------- next state ----------------
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_d     = 1'b0;
    commit_rd_d  = commit_rd_q;
    commit_val_d = commit_val_q;
    commit_pos_d = commit_pos_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_commit) begin
        commit_d     = 1'b1;
        commit_rd_d  = rd_arr[head_q];
        commit_val_d = val_arr[head_q];
        commit_pos_d = head_q;
        head_d       = head_q + 1'b1;
      end
      if (do_issue)
        tail_d = tail_q + 1'b1;
      unique case ({do_issue, do_commit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_q     <= 1'b0;
      commit_rd_q  <= '0;
      commit_val_q <= '0;
      commit_pos_q <= '0;
    end else if (rdy) begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_q     <= commit_d;
      commit_rd_q  <= commit_rd_d;
      commit_val_q <= commit_val_d;
      commit_pos_q <= commit_pos_d;
    end
  end

  // ---------------- operand queries ----------------
  logic [NQ-1:0][ROB_POS_W-1:0] q_pos;
  logic [NQ-1:0]                q_rdy;
  logic [NQ-1:0][DATA_W-1:0]    q_val;

  assign q_pos = {bus.q_rob_pos2, bus.q_rob_pos1};

  for (genvar p = 0; p < NQ; p++) begin : g_q
    logic stored;
    assign stored = busy[q_pos[p]] && ready[q_pos[p]];
`ifdef ROB_QUERY_FWD_EN
    // a writeback landing this cycle on a live entry is already the answer;
    // the busy check keeps a stale tag from resurrecting a freed slot
    logic fwd_hit;
    assign fwd_hit  = bus.wb_valid && (bus.wb_rob_pos == q_pos[p]) &&
                      busy[q_pos[p]];
    assign q_rdy[p] = stored || fwd_hit;
    assign q_val[p] = fwd_hit ? bus.wb_val :
                      stored  ? val_arr[q_pos[p]] : '0;
`else
    assign q_rdy[p] = stored;
    assign q_val[p] = stored ? val_arr[q_pos[p]] : '0;
`endif
  end

  // ---------------- outputs ----------------
  assign bus.issue_rob_pos  = tail_q;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.q_ready1       = q_rdy[0];
  assign bus.q_ready2       = q_rdy[1];
  assign bus.q_val1         = q_val[0];
  assign bus.q_val2         = q_val[1];
  assign bus.commit         = commit_q;
  assign bus.commit_rd      = commit_rd_q;
  assign bus.commit_val     = commit_val_q;
  assign bus.commit_rob_pos = commit_pos_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;
  localparam int ROB_POS_W = 4;
  localparam int DATA_W    = 32;
  localparam int REG_POS_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  rob_commit_ctrl_if #(.ROB_POS_W(ROB_POS_W), .DATA_W(DATA_W), .REG_POS_W(REG_POS_W)) bus ();

  rob_commit_ctrl #(.ROB_POS_W(ROB_POS_W), .DATA_W(DATA_W), .REG_POS_W(REG_POS_W)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue = 1'b0; bus.issue_rd = '0;
    bus.wb_valid = 1'b0; bus.wb_rob_pos = '0; bus.wb_val = '0;
    bus.q_rob_pos1 = '0; bus.q_rob_pos2 = '0;
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue_n(input int n, input int rd_base);
    for (int i = 0; i < n; i++) begin
      bus.issue = 1'b1; bus.issue_rd = REG_POS_W'(rd_base + i);
      tick();
    end
    bus.issue = 1'b0;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", bus.full); end
    checks++; if (bus.commit !== 1'b0 || bus.commit_rd !== 5'd0 || bus.commit_val !== 32'd0 || bus.commit_rob_pos !== 4'd0) begin
      failures++; $display("FAIL reset_commit got=%0h/%0h/%0h/%0h exp=0/0/0/0", bus.commit, bus.commit_rd, bus.commit_val, bus.commit_rob_pos); end
    checks++; if (bus.issue_rob_pos !== 4'd0) begin failures++; $display("FAIL reset_tail got=%0h exp=0", bus.issue_rob_pos); end
    // reset mid-flight, with rdy low, on the edge where pos0 would retire
    issue_n(1, 3);
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'hDEAD;
    tick();
    bus.wb_valid = 1'b0;
    rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1;
    checks++; if (bus.commit !== 1'b0 || bus.empty !== 1'b1 || bus.issue_rob_pos !== 4'd0) begin
      failures++; $display("FAIL reset_midflight commit=%0h empty=%0h tail=%0h exp=0/1/0", bus.commit, bus.empty, bus.issue_rob_pos); end
    tick();
    checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL reset_no_stale got=%0h exp=0", bus.commit); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_single();
    do_reset();
    bus.issue = 1'b1; bus.issue_rd = 5'd5;
    checks++; if (bus.issue_rob_pos !== 4'd0) begin failures++; $display("FAIL single_tag got=%0h exp=0", bus.issue_rob_pos); end
    tick();
    bus.issue = 1'b0;
    checks++; if (bus.empty !== 1'b0 || bus.issue_rob_pos !== 4'd1) begin
      failures++; $display("FAIL single_alloc empty=%0h tail=%0h exp=0/1", bus.empty, bus.issue_rob_pos); end
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'h1234;
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL single_wb_edge got=%0h exp=0", bus.commit); end
    tick();
    checks++; if (bus.commit !== 1'b1 || bus.commit_rd !== 5'd5 || bus.commit_val !== 32'h1234 || bus.commit_rob_pos !== 4'd0) begin
      failures++; $display("FAIL single_commit got=%0h/%0h/%0h/%0h exp=1/5/1234/0", bus.commit, bus.commit_rd, bus.commit_val, bus.commit_rob_pos); end
    tick();
    checks++; if (bus.commit !== 1'b0 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL single_after commit=%0h empty=%0h exp=0/1", bus.commit, bus.empty); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_out_of_order();
    logic [3:0]  wpos [3];
    logic [31:0] wval [3];
    logic [31:0] eval [3];
    wpos = '{4'd2, 4'd1, 4'd0};
    wval = '{32'hC, 32'hB, 32'hA};
    eval = '{32'hA, 32'hB, 32'hC};
    do_reset();
    issue_n(3, 1);
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rob_pos = wpos[i]; bus.wb_val = wval[i];
      tick();
      checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL ooo_early_commit step=%0d got=%0h exp=0", i, bus.commit); end
    end
    bus.wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.commit !== 1'b1 || bus.commit_rob_pos !== 4'(i) || bus.commit_val !== eval[i] || bus.commit_rd !== 5'(i + 1)) begin
        failures++; $display("FAIL ooo_commit%0d got=%0h/pos%0h/val%0h/rd%0h exp=1/pos%0h/val%0h/rd%0h",
                             i, bus.commit, bus.commit_rob_pos, bus.commit_val, bus.commit_rd, i, eval[i], i + 1); end
    end
    tick();
    checks++; if (bus.commit !== 1'b0 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL ooo_drain commit=%0h empty=%0h exp=0/1", bus.commit, bus.empty); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_full_wrap();
    do_reset();
    issue_n(16, 1);
    checks++; if (bus.full !== 1'b1 || bus.empty !== 1'b0 || bus.issue_rob_pos !== 4'd0) begin
      failures++; $display("FAIL full_set full=%0h empty=%0h tail=%0h exp=1/0/0", bus.full, bus.empty, bus.issue_rob_pos); end
    bus.issue = 1'b1; bus.issue_rd = 5'd31;
    tick();
    bus.issue = 1'b0;
    checks++; if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd0) begin
      failures++; $display("FAIL full_reject full=%0h tail=%0h exp=1/0", bus.full, bus.issue_rob_pos); end
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'h77;
    tick();
    bus.wb_valid = 1'b0;
    // retire edge with an issue on it: full is judged pre-edge, so rejected
    bus.issue = 1'b1; bus.issue_rd = 5'd30;
    tick();
    bus.issue = 1'b0;
    checks++; if (bus.commit !== 1'b1 || bus.commit_rob_pos !== 4'd0 || bus.commit_val !== 32'h77 || bus.commit_rd !== 5'd1) begin
      failures++; $display("FAIL full_commit got=%0h/pos%0h/val%0h/rd%0h exp=1/pos0/val77/rd1", bus.commit, bus.commit_rob_pos, bus.commit_val, bus.commit_rd); end
    checks++; if (bus.full !== 1'b0 || bus.issue_rob_pos !== 4'd0) begin
      failures++; $display("FAIL full_commit_issue full=%0h tail=%0h exp=0/0", bus.full, bus.issue_rob_pos); end
    bus.issue = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue = 1'b0;
    checks++; if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd1 || bus.commit !== 1'b0) begin
      failures++; $display("FAIL wrap_issue full=%0h tail=%0h commit=%0h exp=1/1/0", bus.full, bus.issue_rob_pos, bus.commit); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_flush();
    do_reset();
    issue_n(4, 1);
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd1; bus.wb_val = 32'hB;
    tick();
    bus.flush = 1'b1;
    bus.issue = 1'b1; bus.issue_rd = 5'd7;
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'hA;
    tick();
    idle();
    checks++; if (bus.empty !== 1'b1 || bus.commit !== 1'b0 || bus.issue_rob_pos !== 4'd0) begin
      failures++; $display("FAIL flush_state empty=%0h commit=%0h tail=%0h exp=1/0/0", bus.empty, bus.commit, bus.issue_rob_pos); end
    bus.q_rob_pos1 = 4'd1;
    #1;
    checks++; if (bus.q_ready1 !== 1'b0 || bus.q_val1 !== 32'd0) begin
      failures++; $display("FAIL flush_query rdy=%0h val=%0h exp=0/0", bus.q_ready1, bus.q_val1); end
    bus.issue = 1'b1; bus.issue_rd = 5'd8;
    tick();
    bus.issue = 1'b0;
    checks++; if (bus.issue_rob_pos !== 4'd1 || bus.empty !== 1'b0) begin
      failures++; $display("FAIL flush_reissue tail=%0h empty=%0h exp=1/0", bus.issue_rob_pos, bus.empty); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL flush_stale cyc=%0d got=%0h exp=0", i, bus.commit); end
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_stall();
    do_reset();
    issue_n(1, 6);
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'h99;
    tick();
    bus.wb_valid = 1'b0;
    rdy = 1'b0;
    bus.issue = 1'b1; bus.issue_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.commit !== 1'b0 || bus.issue_rob_pos !== 4'd1 || bus.empty !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc=%0d commit=%0h tail=%0h empty=%0h exp=0/1/0", i, bus.commit, bus.issue_rob_pos, bus.empty); end
    end
    bus.issue = 1'b0;
    rdy = 1'b1;
    tick();
    checks++; if (bus.commit !== 1'b1 || bus.commit_val !== 32'h99 || bus.commit_rob_pos !== 4'd0 || bus.commit_rd !== 5'd6 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%0h/val%0h/pos%0h/rd%0h/empty%0h exp=1/val99/pos0/rd6/empty1",
                           bus.commit, bus.commit_val, bus.commit_rob_pos, bus.commit_rd, bus.empty); end
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.commit !== 1'b1 || bus.commit_val !== 32'h99) begin
        failures++; $display("FAIL stall_pulse_hold cyc=%0d got=%0h/val%0h exp=1/val99", i, bus.commit, bus.commit_val); end
    end
    rdy = 1'b1;
    tick();
    checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL stall_single_pulse got=%0h exp=0", bus.commit); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_query();
    do_reset();
    issue_n(4, 1);
    bus.q_rob_pos1 = 4'd3; bus.q_rob_pos2 = 4'd0;
    #1;
    checks++; if (bus.q_ready1 !== 1'b0 || bus.q_val1 !== 32'd0) begin
      failures++; $display("FAIL query_busy rdy=%0h val=%0h exp=0/0", bus.q_ready1, bus.q_val1); end
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd3; bus.wb_val = 32'h55;
    #1;
`ifdef ROB_QUERY_FWD_EN
    checks++; if (bus.q_ready1 !== 1'b1 || bus.q_val1 !== 32'h55) begin
      failures++; $display("FAIL query_same_cycle rdy=%0h val=%0h exp=1/55", bus.q_ready1, bus.q_val1); end
`else
    checks++; if (bus.q_ready1 !== 1'b0 || bus.q_val1 !== 32'd0) begin
      failures++; $display("FAIL query_same_cycle rdy=%0h val=%0h exp=0/0", bus.q_ready1, bus.q_val1); end
`endif
    checks++; if (bus.q_ready2 !== 1'b0 || bus.q_val2 !== 32'd0) begin
      failures++; $display("FAIL query_other rdy=%0h val=%0h exp=0/0", bus.q_ready2, bus.q_val2); end
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.q_ready1 !== 1'b1 || bus.q_val1 !== 32'h55) begin
      failures++; $display("FAIL query_next rdy=%0h val=%0h exp=1/55", bus.q_ready1, bus.q_val1); end
    // writeback to a free slot is dropped and never visible
    bus.q_rob_pos2 = 4'd5;
    bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd5; bus.wb_val = 32'h66;
    #1;
    checks++; if (bus.q_ready2 !== 1'b0 || bus.q_val2 !== 32'd0) begin
      failures++; $display("FAIL query_free_fwd rdy=%0h val=%0h exp=0/0", bus.q_ready2, bus.q_val2); end
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.q_ready2 !== 1'b0 || bus.q_val2 !== 32'd0) begin
      failures++; $display("FAIL query_free_slot rdy=%0h val=%0h exp=0/0", bus.q_ready2, bus.q_val2); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_flush();
    test_stall();
    test_query();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
